// File: rtl/loader_pkg.sv
// Shared types and default widths for the program loader and the MAR/RAM it feeds.
package loader_pkg;

  // Default widths, matching the MAR/RAM datapath.
  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int DEFAULT_DATA_WIDTH = 8;

  // Loader FSM states.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_DATA  = 3'd1,
    DRIVE_ADDR = 3'd2,
    DRIVE_DATA = 3'd3,
    RELEASE    = 3'd4
  } loader_state_t;

  // True in the two states where the loader owns the shared bus.
  function automatic logic is_bus_phase(input loader_state_t s);
    return (s == DRIVE_ADDR) || (s == DRIVE_DATA);
  endfunction

endpackage

// File: rtl/program_loader.sv
// Bus-master program loader. It takes bytes from a valid/ready stream and
// writes each one into RAM as a MAR-load / RAM-load pair on the shared bus.
// The control unit and PC are held in reset (ctrl_hold) for the whole load.
// Every output except data_ready is a register, loaded from the decoded
// next state, so strobes are glitch-free and line up with the state.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LOAD_WORDS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic [DATA_WIDTH-1:0] bus_out,
  output logic                  bus_oe,
  output logic                  mar_load,
  output logic                  ram_load,
  output logic                  ctrl_hold,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
);

  // Address of the final byte. The counter stops here and never wraps.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LOAD_WORDS - 1);

  loader_state_t         state;
  loader_state_t         state_next;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [DATA_WIDTH-1:0] data_next;
  logic                  aborted_flag;
  logic                  flag_next;

  // Stream handshake: take a byte only while waiting and not being aborted.
  always_comb begin
    data_ready = (state == WAIT_DATA) && !abort;
  end

  // Next-state, counter, data and abort-flag logic.
  always_comb begin
    state_next = state;
    addr_next  = addr_cnt;
    data_next  = data_reg;
    flag_next  = aborted_flag;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = WAIT_DATA;
          addr_next  = {ADDR_WIDTH{1'b0}};
          flag_next  = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT_DATA: begin
        if (abort) begin
          // Abort beats a simultaneous data_valid; the byte is not consumed.
          state_next = RELEASE;
          flag_next  = 1'b1;
        end else if (data_valid) begin
          state_next = DRIVE_ADDR;
          data_next  = data_in;
        end else begin
          state_next = WAIT_DATA;
        end
      end
      DRIVE_ADDR: begin
        // The MAR/RAM pair is never split: abort is only remembered here.
        state_next = DRIVE_DATA;
        if (abort) begin
          flag_next = 1'b1;
        end else begin
          flag_next = aborted_flag;
        end
      end
      DRIVE_DATA: begin
        if (addr_cnt == LAST_ADDR) begin
          state_next = RELEASE;
          flag_next  = aborted_flag | abort;
        end else if (aborted_flag || abort) begin
          // Pending abort takes effect at the WAIT_DATA boundary.
          state_next = RELEASE;
          flag_next  = 1'b1;
        end else begin
          state_next = WAIT_DATA;
          addr_next  = addr_cnt + ADDR_WIDTH'(1);
        end
      end
      RELEASE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        flag_next  = 1'b0;
      end
    endcase
  end

  // State, datapath registers and registered output decode from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      addr_cnt     <= {ADDR_WIDTH{1'b0}};
      data_reg     <= {DATA_WIDTH{1'b0}};
      aborted_flag <= 1'b0;
      bus_out      <= {DATA_WIDTH{1'b0}};
      bus_oe       <= 1'b0;
      mar_load     <= 1'b0;
      ram_load     <= 1'b0;
      ctrl_hold    <= 1'b0;
      addr         <= {ADDR_WIDTH{1'b0}};
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      state        <= state_next;
      addr_cnt     <= addr_next;
      data_reg     <= data_next;
      aborted_flag <= flag_next;
      bus_oe       <= is_bus_phase(state_next);
      mar_load     <= (state_next == DRIVE_ADDR);
      ram_load     <= (state_next == DRIVE_DATA);
      ctrl_hold    <= (state_next != IDLE);
      busy         <= (state_next != IDLE);
      done         <= (state_next == RELEASE);
      aborted      <= (state_next == RELEASE) && flag_next;
      if (state_next == IDLE) begin
        addr <= {ADDR_WIDTH{1'b0}};
      end else begin
        addr <= addr_next;
      end
      case (state_next)
        DRIVE_ADDR: bus_out <= DATA_WIDTH'(addr_next);
        DRIVE_DATA: bus_out <= data_next;
        default:    bus_out <= {DATA_WIDTH{1'b0}};
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader. Each scenario is planned up front:
// the stimulus per cycle and the expected outputs per cycle are derived from
// the loader's timing rules (3 cycles per byte after acceptance, release one
// cycle after the last RAM write or an abort). A RAM model fed by the DUT
// strobes is compared with the bytes the plan says were accepted.
module tb_program_loader;

  localparam int DEPTH = 160;
  localparam logic [18:0] FULL_MASK = 19'h7FFFF;
  localparam logic [18:0] REL_MASK  = 19'h7F0FF;  // addr not compared in RELEASE

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start16, start4, abort, data_valid;
  logic [7:0] data_in;

  logic       rdy16, oe16, mar16, ram16, hold16, busy16, done16, ab16;
  logic [7:0] bus16;
  logic [3:0] addr16;
  logic       rdy4, oe4, mar4, ram4, hold4, busy4, done4, ab4;
  logic [7:0] bus4;
  logic [3:0] addr4;

  program_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .LOAD_WORDS(16)) dut (
    .clk(clk), .rst(rst), .start(start16), .abort(abort), .data_in(data_in),
    .data_valid(data_valid), .data_ready(rdy16), .bus_out(bus16), .bus_oe(oe16),
    .mar_load(mar16), .ram_load(ram16), .ctrl_hold(hold16), .addr(addr16),
    .busy(busy16), .done(done16), .aborted(ab16)
  );

  program_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .LOAD_WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort), .data_in(data_in),
    .data_valid(data_valid), .data_ready(rdy4), .bus_out(bus4), .bus_oe(oe4),
    .mar_load(mar4), .ram_load(ram4), .ctrl_hold(hold4), .addr(addr4),
    .busy(busy4), .done(done4), .aborted(ab4)
  );

  logic [18:0] obs16, obs4;
  assign obs16 = {oe16, mar16, ram16, hold16, busy16, done16, ab16, addr16, bus16};
  assign obs4  = {oe4, mar4, ram4, hold4, busy4, done4, ab4, addr4, bus4};

  // Planned stimulus and expectations, indexed by clock edge.
  logic        s_start [DEPTH];
  logic        s_abort [DEPTH];
  logic        s_rst   [DEPTH];
  logic        s_valid [DEPTH];
  logic [7:0]  s_data  [DEPTH];
  logic [18:0] e_out   [DEPTH];
  logic [18:0] e_mask  [DEPTH];
  logic        e_rdy   [DEPTH];
  int          e_last;

  logic [7:0] exp_ram [16];
  logic [7:0] obs_ram [16];
  logic [3:0] obs_mar;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] vec(input logic oe, input logic mar, input logic ram,
                                      input logic hold, input logic bsy, input logic dn,
                                      input logic ab, input logic [3:0] a, input logic [7:0] b);
    return {oe, mar, ram, hold, bsy, dn, ab, a, b};
  endfunction

  // Plan one load. mode: 0 none, 1 abort while waiting for byte k (with
  // data_valid high), 2 abort in DRIVE_ADDR of byte k, 3 abort in DRIVE_DATA
  // of byte k, 4 reset in DRIVE_ADDR of byte k.
  task automatic build(input int lw, input int mode, input int k, input int gap_at,
                       input int gap_len, input bit rnd_gaps, input bit seq_data);
    int ws, acc, g;
    logic [7:0] b;
    logic ab;
    for (int c = 0; c < DEPTH; c++) begin
      s_start[c] = 1'($urandom);
      s_abort[c] = 1'b0;
      s_rst[c]   = 1'b0;
      s_valid[c] = 1'($urandom);
      s_data[c]  = 8'($urandom);
      e_out[c]   = 19'h00000;
      e_mask[c]  = FULL_MASK;
      e_rdy[c]   = 1'b0;
    end
    for (int j = 0; j < 16; j++) exp_ram[j] = 8'hEE;
    s_start[0] = 1'b1;
    ws = 1;
    e_last = 0;
    for (int i = 0; i < lw; i++) begin
      g   = rnd_gaps ? int'($urandom_range(0, 3)) : ((i == gap_at) ? gap_len : 0);
      acc = ws + g;
      for (int c = ws; c <= acc; c++) begin
        e_out[c-1] = vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'(i), 8'h00);
        e_rdy[c]   = 1'b1;
        if (c < acc) s_valid[c] = 1'b0;
      end
      if (mode == 1 && i == k) begin
        s_abort[acc] = 1'b1;
        s_valid[acc] = 1'b1;
        e_rdy[acc]   = 1'b0;
        e_out[acc]   = vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 8'h00);
        e_mask[acc]  = REL_MASK;
        e_last       = acc + 1;
        break;
      end
      b = seq_data ? 8'(8'h10 + i) : 8'($urandom);
      s_valid[acc] = 1'b1;
      s_data[acc]  = b;
      e_out[acc]   = vec(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'(i), 8'(i));
      if (mode == 4 && i == k) begin
        s_rst[acc+1] = 1'b1;
        e_last       = acc + 1;
        break;
      end
      exp_ram[i]   = b;
      e_out[acc+1] = vec(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'(i), b);
      ab = ((mode == 2) || (mode == 3)) && (i == k);
      if (mode == 2 && i == k) s_abort[acc+1] = 1'b1;
      if (mode == 3 && i == k) s_abort[acc+2] = 1'b1;
      if (ab || i == lw - 1) begin
        e_out[acc+2]  = vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, ab, 4'h0, 8'h00);
        e_mask[acc+2] = REL_MASK;
        e_last        = acc + 3;
        break;
      end
      ws = acc + 3;
    end
  endtask

  // Play the planned load on the selected instance (0: 16 words, 1: 4 words).
  task automatic run(input bit sel);
    logic [18:0] obs, other;
    logic        other_rdy;
    for (int j = 0; j < 16; j++) obs_ram[j] = 8'hEE;
    obs_mar = 4'h0;
    for (int c = 0; c <= e_last; c++) begin
      rst        = s_rst[c];
      abort      = s_abort[c];
      data_valid = s_valid[c];
      data_in    = s_data[c];
      start16    = sel ? 1'b0 : s_start[c];
      start4     = sel ? s_start[c] : 1'b0;
      #1;
      check($sformatf("ready c%0d", c), 32'(sel ? rdy4 : rdy16), 32'(e_rdy[c]));
      @(posedge clk);
      @(negedge clk);
      obs       = sel ? obs4 : obs16;
      other     = sel ? obs16 : obs4;
      other_rdy = sel ? rdy16 : rdy4;
      check($sformatf("outs c%0d", c), 32'(obs & e_mask[c]), 32'(e_out[c]));
      check($sformatf("idle_other c%0d", c), 32'({other_rdy, other}), 32'h0);
      if (obs[17]) obs_mar = obs[3:0];
      if (obs[16]) obs_ram[obs_mar] = obs[7:0];
    end
    for (int j = 0; j < 16; j++) check($sformatf("ram[%0d]", j), 32'(obs_ram[j]), 32'(exp_ram[j]));
  endtask

  initial begin
    bit sel;
    int lw;
    rst = 1'b1; start16 = 1'b0; start4 = 1'b0; abort = 1'b0;
    data_valid = 1'b0; data_in = 8'h00;
    repeat (2) @(negedge clk);
    check("reset16", 32'({rdy16, obs16}), 32'h0);
    check("reset4", 32'({rdy4, obs4}), 32'h0);
    rst = 1'b0;

    build(16, 0, 0, -1, 0, 1'b0, 1'b1); run(1'b0);   // continuous, bytes 10..1F
    build(16, 0, 0, 3, 5, 1'b0, 1'b0);  run(1'b0);   // backpressure before byte 4
    build(16, 1, 6, -1, 0, 1'b0, 1'b0); run(1'b0);   // abort waiting for byte 7
    build(16, 3, 1, -1, 0, 1'b0, 1'b0); run(1'b0);   // abort in DRIVE_DATA of byte 2
    build(16, 2, 4, -1, 0, 1'b0, 1'b0); run(1'b0);   // abort in DRIVE_ADDR
    build(16, 4, 3, -1, 0, 1'b0, 1'b0); run(1'b0);   // reset mid-load
    build(16, 0, 0, -1, 0, 1'b1, 1'b0); run(1'b0);   // fresh load after reset
    build(4, 0, 0, -1, 0, 1'b1, 1'b0);  run(1'b1);   // LOAD_WORDS=4
    build(4, 3, 3, -1, 0, 1'b0, 1'b0);  run(1'b1);   // abort on last byte

    for (int r = 0; r < 6; r++) begin
      sel = 1'($urandom);
      lw  = sel ? 4 : 16;
      build(lw, int'($urandom_range(0, 4)), int'($urandom_range(0, lw - 1)), -1, 0, 1'b1, 1'b0);
      run(sel);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
